key_insn_injector: RTL

- Processor-side consumer of the key-input instruction stream.
- Accepts the one-cycle key-press pulse and its associated 32-bit instruction, and buffers them in a small FIFO.
- Splices buffered instructions into the fetch stream in place of the instruction-memory word, holding the PC so no program instruction is lost.
- Sits between instruction memory and the fetch/decode latch; obeys the hazard unit's stall.

---
 rtl/key_insn_injector_if.sv | 29 ++
 rtl/key_insn_injector.sv | 108 ++++++++++
 2 files changed

// File: rtl/key_insn_injector_if.sv
// Bundles the key-instruction stream, the imem/fetch path and the status outputs of key_insn_injector.
// Latency: none (wires only).
// Backpressure: stall_in is the only throttle; a key press that finds the FIFO full is dropped, never held.
interface key_insn_injector_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 2
);
  logic              key_pressed_in;
  logic [WIDTH-1:0]  insn_key_in;
  logic [WIDTH-1:0]  imem_insn_in;
  logic              stall_in;
  logic [WIDTH-1:0]  insn_out;
  logic              pc_hold_out;
  logic              injecting_out;
  logic [ADDR_W:0]   fifo_count_out;
  logic              overflow_out;

  // Key block, imem and hazard unit side: drives the inputs and watches the results.
  modport master (
    output key_pressed_in, insn_key_in, imem_insn_in, stall_in,
    input  insn_out, pc_hold_out, injecting_out, fifo_count_out, overflow_out
  );

  // Injector side.
  modport slave (
    input  key_pressed_in, insn_key_in, imem_insn_in, stall_in,
    output insn_out, pc_hold_out, injecting_out, fifo_count_out, overflow_out
  );
endinterface

// File: rtl/key_insn_injector.sv
// Buffers key-press instructions and splices them into the fetch stream in place of imem words, holding the PC.
// Latency: an entry pushed at edge N can be injected in the cycle after edge N at the earliest; injection itself is combinational.
// Backpressure: stall_in blocks injection; a press arriving while full with no pop is dropped and sets sticky overflow.
module key_insn_injector #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int WIDTH  = 32
) (
  input  logic            clk_in,
  input  logic            reset,
  key_insn_injector_if.slave bus
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // IDLE may inject; YIELD guarantees one program word passes before the next injection.
  typedef enum logic {
    IDLE  = 1'b0,
    YIELD = 1'b1
  } state_t;

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic              overflow_q, overflow_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic push_req;
  logic push_ok;
  logic inject;

  // Push/pop decisions for this cycle; injection is decided from the live stall.
  always_comb begin
    push_req = bus.key_pressed_in && (bus.insn_key_in != '0);
    inject   = (state_q == IDLE) && (count_q != '0) && !bus.stall_in;
    // A same-cycle pop frees the slot, so a push while full is still accepted then.
    push_ok  = push_req && ((count_q != CNT_FULL) || inject);
  end

  // Next-state computation for pointers, occupancy, overflow and the inject/yield FSM.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (inject) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    unique case ({push_ok, inject})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end

    unique case (state_q)
      IDLE:    state_d = inject ? YIELD : IDLE;
      YIELD:   state_d = bus.stall_in ? YIELD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: cleared asynchronously so a mid-operation reset drops every queued entry.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= bus.insn_key_in;
    end
  end

  // Output mux: FIFO head replaces the imem word on an inject cycle, otherwise pass-through.
  always_comb begin
    bus.insn_out       = inject ? mem_q[rd_ptr_q] : bus.imem_insn_in;
    bus.pc_hold_out    = inject;
    bus.injecting_out  = inject;
    bus.fifo_count_out = count_q;
    bus.overflow_out   = overflow_q;
  end

endmodule
